// File: rtl/id_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_exe_stage
//  Function : RV32I decode stage with bypassed register file, immediate
//             generation and ID/EX pipeline register with load-use stall.
//  Revision : 1.0
// ============================================================================
module id_exe_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    output logic                        id_ready,
    input  logic [31:0]                 id_instr,
    input  logic [XLEN-1:0]             id_pc,
    input  logic                        flush,
    input  logic                        wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    output logic                        ex_valid,
    input  logic                        ex_ready,
    output logic [XLEN-1:0]             ex_pc,
    output logic [XLEN-1:0]             ex_rs1_data,
    output logic [XLEN-1:0]             ex_rs2_data,
    output logic [XLEN-1:0]             ex_imm,
    output logic [$clog2(NUM_REGS)-1:0] ex_rs1,
    output logic [$clog2(NUM_REGS)-1:0] ex_rs2,
    output logic [$clog2(NUM_REGS)-1:0] ex_rd,
    output logic [6:0]                  ex_opcode,
    output logic [2:0]                  ex_funct3,
    output logic [6:0]                  ex_funct7,
    output logic                        ex_reg_write,
    output logic                        ex_mem_read
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_writes;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_hazard;
    logic            w_advance;
    logic            w_accept;

    logic [XLEN-1:0] r_regs [NUM_REGS];

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [AW-1:0]   r_rd;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic            r_reg_write;
    logic            r_mem_read;

    // Register index fields are truncated to the configured register count
    assign w_opcode = id_instr[6:0];
    assign w_rd     = id_instr[7 +: AW];
    assign w_funct3 = id_instr[14:12];
    assign w_rs1    = id_instr[15 +: AW];
    assign w_rs2    = id_instr[20 +: AW];
    assign w_funct7 = id_instr[31:25];

    always_comb begin
        w_imm32 = '0;
        case (w_opcode)
            c_op_load, c_op_imm, c_op_jalr:
                w_imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
            c_op_store:
                w_imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            c_op_branch:
                w_imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                           id_instr[30:25], id_instr[11:8], 1'b0};
            c_op_lui, c_op_auipc:
                w_imm32 = {id_instr[31:12], 12'b0};
            c_op_jal:
                w_imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                           id_instr[20], id_instr[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
        w_imm       = {XLEN{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    assign w_rs1_used = !((w_opcode == c_op_lui) || (w_opcode == c_op_auipc) ||
                          (w_opcode == c_op_jal));
    assign w_rs2_used = (w_opcode == c_op_reg) || (w_opcode == c_op_store) ||
                        (w_opcode == c_op_branch);
    assign w_writes   = (w_opcode == c_op_reg)  || (w_opcode == c_op_imm)   ||
                        (w_opcode == c_op_load) || (w_opcode == c_op_lui)   ||
                        (w_opcode == c_op_auipc) || (w_opcode == c_op_jal)  ||
                        (w_opcode == c_op_jalr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Same-cycle write-back is forwarded so the decoded operand is never stale
    assign w_rs1_data = (w_rs1 == '0) ? '0 :
                        (wb_en && (wb_addr == w_rs1)) ? wb_data : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 :
                        (wb_en && (wb_addr == w_rs2)) ? wb_data : r_regs[w_rs2];

    assign w_hazard  = r_valid && r_mem_read && (r_rd != '0) &&
                       ((w_rs1_used && (r_rd == w_rs1)) ||
                        (w_rs2_used && (r_rd == w_rs2)));
    assign w_advance = !r_valid || ex_ready;
    assign id_ready  = w_advance && !w_hazard && !flush;
    assign w_accept  = id_valid && !w_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_pc        <= id_pc;
                r_rs1_data  <= w_rs1_data;
                r_rs2_data  <= w_rs2_data;
                r_imm       <= w_imm;
                r_rs1       <= w_rs1;
                r_rs2       <= w_rs2;
                r_rd        <= w_rd;
                r_opcode    <= w_opcode;
                r_funct3    <= w_funct3;
                r_funct7    <= w_funct7;
                r_reg_write <= w_writes && (w_rd != '0);
                r_mem_read  <= (w_opcode == c_op_load);
            end
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_opcode    = r_opcode;
    assign ex_funct3    = r_funct3;
    assign ex_funct7    = r_funct7;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_exe_stage
//  Function : Directed vector table plus randomized run against a reference
//             model, on a 32/32 and a 64/16 instance sharing one stimulus.
//  Revision : 1.0
// ============================================================================
module tb_id_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, flush, wb_en, ex_ready;
    logic [31:0] instr;
    logic [63:0] pc, wbd;
    logic [4:0]  wba;

    logic        a_id_ready, a_ex_valid, a_rw, a_mr;
    logic [31:0] a_pc, a_rs1d, a_rs2d, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3;

    logic        b_id_ready, b_ex_valid, b_rw, b_mr;
    logic [63:0] b_pc, b_rs1d, b_rs2d, b_imm;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_exe_stage #(.XLEN(32), .NUM_REGS(32)) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(a_id_ready),
        .id_instr(instr), .id_pc(pc[31:0]), .flush(flush), .wb_en(wb_en),
        .wb_addr(wba), .wb_data(wbd[31:0]), .ex_valid(a_ex_valid),
        .ex_ready(ex_ready), .ex_pc(a_pc), .ex_rs1_data(a_rs1d),
        .ex_rs2_data(a_rs2d), .ex_imm(a_imm), .ex_rs1(a_rs1), .ex_rs2(a_rs2),
        .ex_rd(a_rd), .ex_opcode(a_op), .ex_funct3(a_f3), .ex_funct7(a_f7),
        .ex_reg_write(a_rw), .ex_mem_read(a_mr)
    );

    id_exe_stage #(.XLEN(64), .NUM_REGS(16)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(b_id_ready),
        .id_instr(instr), .id_pc(pc), .flush(flush), .wb_en(wb_en),
        .wb_addr(wba[3:0]), .wb_data(wbd), .ex_valid(b_ex_valid),
        .ex_ready(ex_ready), .ex_pc(b_pc), .ex_rs1_data(b_rs1d),
        .ex_rs2_data(b_rs2d), .ex_imm(b_imm), .ex_rs1(b_rs1), .ex_rs2(b_rs2),
        .ex_rd(b_rd), .ex_opcode(b_op), .ex_funct3(b_f3), .ex_funct7(b_f7),
        .ex_reg_write(b_rw), .ex_mem_read(b_mr)
    );

    // Reference model state, index 0 = 32-bit/32-reg, 1 = 64-bit/16-reg
    bit          mv  [2];
    logic [63:0] mpc [2], mrs1d [2], mrs2d [2], mimm [2];
    int          mrs1 [2], mrs2 [2], mrd [2];
    logic [6:0]  mop [2], mf7 [2];
    logic [2:0]  mf3 [2];
    bit          mrw [2], mmr [2];
    logic [63:0] mrf [2][32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fit(input int k, input logic [63:0] v);
        return (k == 0) ? {32'b0, v[31:0]} : v;
    endfunction

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int k);
        int     v;
        longint l;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: v = int'($signed(ins[31:20]));
            7'h23: v = int'($signed({ins[31:25], ins[11:7]}));
            7'h63: v = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h37, 7'h17: v = int'({ins[31:12], 12'b0});
            7'h6F: v = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: v = 0;
        endcase
        l = v;
        return fit(k, l);
    endfunction

    function automatic logic [63:0] rf_read(input int k, input int r, input int wa,
                                            input logic [63:0] wd);
        if (r == 0) return 64'd0;
        if (wb_en && (wa == r)) return wd;
        return mrf[k][r];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mpc[k] = 0; mrs1d[k] = 0; mrs2d[k] = 0; mimm[k] = 0;
            mrs1[k] = 0; mrs2[k] = 0; mrd[k] = 0; mop[k] = 0; mf7[k] = 0;
            mf3[k] = 0; mrw[k] = 0; mmr[k] = 0;
            for (int r = 0; r < 32; r++) mrf[k][r] = 0;
        end
    endtask

    // Evaluated just before the rising edge; leaves the model in post-edge state
    task automatic model_step(input int k);
        int          n, rs1, rs2, rd, wa;
        logic [6:0]  op;
        logic [63:0] wd;
        bit          u1, u2, haz, adv, rdy;
        n   = nregs(k);
        op  = instr[6:0];
        rs1 = int'(instr[19:15]) % n;
        rs2 = int'(instr[24:20]) % n;
        rd  = int'(instr[11:7]) % n;
        wa  = int'(wba) % n;
        wd  = fit(k, wbd);
        u1  = !(op inside {7'h37, 7'h17, 7'h6F});
        u2  = op inside {7'h33, 7'h23, 7'h63};
        haz = mv[k] && mmr[k] && (mrd[k] != 0) &&
              ((u1 && (mrd[k] == rs1)) || (u2 && (mrd[k] == rs2)));
        adv = !mv[k] || ex_ready;
        rdy = adv && !haz && !flush;
        chk($sformatf("%s id_ready", k ? "B" : "A"), k ? b_id_ready : a_id_ready, rdy);
        if (flush) begin
            mv[k] = 0;
        end else if (adv) begin
            mv[k] = id_valid && !haz;
            if (mv[k]) begin
                mpc[k]   = fit(k, pc);
                mrs1d[k] = rf_read(k, rs1, wa, wd);
                mrs2d[k] = rf_read(k, rs2, wa, wd);
                mimm[k]  = ref_imm(instr, k);
                mrs1[k]  = rs1;
                mrs2[k]  = rs2;
                mrd[k]   = rd;
                mop[k]   = op;
                mf3[k]   = instr[14:12];
                mf7[k]   = instr[31:25];
                mrw[k]   = (rd != 0) && (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67});
                mmr[k]   = (op == 7'h03);
            end
        end
        if (wb_en && (wa != 0)) mrf[k][wa] = wd;
    endtask

    task automatic model_check(input int k);
        string t;
        t = k ? "B" : "A";
        if (k == 0) begin
            chk({t, " ex_valid"}, a_ex_valid, mv[0]);
            if (mv[0]) begin
                chk({t, " ex_pc"}, a_pc, mpc[0]);
                chk({t, " ex_rs1_data"}, a_rs1d, mrs1d[0]);
                chk({t, " ex_rs2_data"}, a_rs2d, mrs2d[0]);
                chk({t, " ex_imm"}, a_imm, mimm[0]);
                chk({t, " ex_idx"}, {a_rs1, a_rs2, a_rd}, {mrs1[0][4:0], mrs2[0][4:0], mrd[0][4:0]});
                chk({t, " ex_fields"}, {a_op, a_f3, a_f7, a_rw, a_mr},
                    {mop[0], mf3[0], mf7[0], mrw[0], mmr[0]});
            end
        end else begin
            chk({t, " ex_valid"}, b_ex_valid, mv[1]);
            if (mv[1]) begin
                chk({t, " ex_pc"}, b_pc, mpc[1]);
                chk({t, " ex_rs1_data"}, b_rs1d, mrs1d[1]);
                chk({t, " ex_rs2_data"}, b_rs2d, mrs2d[1]);
                chk({t, " ex_imm"}, b_imm, mimm[1]);
                chk({t, " ex_idx"}, {b_rs1, b_rs2, b_rd}, {mrs1[1][3:0], mrs2[1][3:0], mrd[1][3:0]});
                chk({t, " ex_fields"}, {b_op, b_f3, b_f7, b_rw, b_mr},
                    {mop[1], mf3[1], mf7[1], mrw[1], mmr[1]});
            end
        end
    endtask

    task automatic cycle(input bit has_exp, input bit exp_rdy, input string tag);
        #1;
        if (has_exp) chk({tag, " A id_ready"}, a_id_ready, exp_rdy);
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        model_check(0);
        model_check(1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " A valid/pc"}, {a_ex_valid, a_pc}, 64'd0);
        chk({tag, " A data"}, {a_rs1d, a_rs2d}, 64'd0);
        chk({tag, " A imm/fields"}, {a_imm, a_rs1, a_rs2, a_rd, a_op, a_f3, a_f7, a_rw, a_mr}, 64'd0);
        chk({tag, " B valid"}, b_ex_valid, 64'd0);
        chk({tag, " B pc"}, b_pc, 64'd0);
        chk({tag, " B rs1/rs2"}, b_rs1d | b_rs2d, 64'd0);
        chk({tag, " B imm"}, b_imm, 64'd0);
        chk({tag, " B fields"}, {b_rs1, b_rs2, b_rd, b_op, b_f3, b_f7, b_rw, b_mr}, 64'd0);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] ins;
        bit          rdy;
        bit          fl;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          e_rdy;
        bit          e_v;
        bit          chk;
        logic [4:0]  e_rd;
        logic [31:0] e_imm;
        logic [31:0] e_rs1d;
        logic [31:0] e_rs2d;
        logic [63:0] e_imm_b;
        logic [31:0] e_rs1d_b;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t       tbl [16];
    logic [6:0] ops [11];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 32'h0,        1, 0, 1, 5'd5,  32'h12345678, 1, 0, 1, 5'd0,  32'h0,        32'h0,        32'h0,  64'h0, 32'h0};
        tbl[1]  = '{1, 32'h000280B3, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd1,  32'h0,        32'h12345678, 32'h0,  64'h0, 32'h12345678};
        tbl[2]  = '{1, 32'hFFF00113, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd2,  32'hFFFFFFFF, 32'h0,        32'h0,  ONES,  32'h0};
        tbl[3]  = '{1, 32'hABCDE1B7, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd3,  32'hABCDE000, 32'h0,        32'h0,  64'hFFFFFFFF_ABCDE000, 32'h0};
        tbl[4]  = '{1, 32'hFE000EE3, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd29, 32'hFFFFFFFC, 32'h0,        32'h0,  64'hFFFFFFFF_FFFFFFFC, 32'h0};
        tbl[5]  = '{1, 32'h0000A383, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd7,  32'h0,        32'h0,        32'h0,  64'h0, 32'h0};
        tbl[6]  = '{1, 32'h00738433, 1, 0, 0, 5'd0,  32'h0,        0, 0, 1, 5'd7,  32'h0,        32'h0,        32'h0,  64'h0, 32'h0};
        tbl[7]  = '{1, 32'h00738433, 1, 0, 1, 5'd7,  32'h55,       1, 1, 1, 5'd8,  32'h0,        32'h55,       32'h55, 64'h0, 32'h55};
        tbl[8]  = '{1, 32'hFFF00113, 0, 0, 0, 5'd0,  32'h0,        0, 1, 1, 5'd8,  32'h0,        32'h55,       32'h55, 64'h0, 32'h55};
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = '{1, 32'hFFF00113, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd2,  32'hFFFFFFFF, 32'h0,        32'h0,  ONES,  32'h0};
        tbl[12] = '{1, 32'hABCDE1B7, 0, 1, 1, 5'd0,  32'hDEAD,     0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,  64'h0, 32'h0};
        tbl[13] = '{1, 32'hFFF00113, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd2,  32'hFFFFFFFF, 32'h0,        32'h0,  ONES,  32'h0};
        tbl[14] = '{1, 32'h01108533, 1, 0, 1, 5'd17, 32'h77,       1, 1, 1, 5'd10, 32'h0,        32'h0,        32'h77, 64'h0, 32'h77};
        tbl[15] = '{1, 32'h000085B3, 1, 0, 0, 5'd0,  32'h0,        1, 1, 1, 5'd11, 32'h0,        32'h0,        32'h0,  64'h0, 32'h77};
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};

        id_valid = 0; flush = 0; wb_en = 0; ex_ready = 1;
        instr = 0; pc = 0; wbd = 0; wba = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_zero("por");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            id_valid = tbl[i].v;    instr = tbl[i].ins;  ex_ready = tbl[i].rdy;
            flush    = tbl[i].fl;   wb_en = tbl[i].we;   wba = tbl[i].wa;
            wbd      = {32'h0, tbl[i].wd};
            pc       = 64'h1000 + 64'(i * 4);
            cycle(1'b1, tbl[i].e_rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d A ex_valid", i), a_ex_valid, tbl[i].e_v);
            chk($sformatf("vec%0d B ex_valid", i), b_ex_valid, tbl[i].e_v);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d A ex_rd", i), a_rd, tbl[i].e_rd);
                chk($sformatf("vec%0d A ex_imm", i), a_imm, tbl[i].e_imm);
                chk($sformatf("vec%0d A ex_rs1_data", i), a_rs1d, tbl[i].e_rs1d);
                chk($sformatf("vec%0d A ex_rs2_data", i), a_rs2d, tbl[i].e_rs2d);
                chk($sformatf("vec%0d B ex_imm", i), b_imm, tbl[i].e_imm_b);
                chk($sformatf("vec%0d B ex_rs1_data", i), b_rs1d, {32'h0, tbl[i].e_rs1d_b});
            end
        end

        // Asynchronous reset while a bundle is valid, mid-cycle
        chk("pre-reset A ex_valid", a_ex_valid, 64'd1);
        id_valid = 0; wb_en = 0;
        #2 rst = 1'b0;
        #1 chk_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 500; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 7) != 0) begin
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                ins[11:7]  = 5'($urandom_range(0, 7));
            end
            instr    = ins;
            id_valid = ($urandom_range(0, 9) < 8);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 9) == 0);
            wb_en    = $urandom_range(0, 1) == 1;
            wba      = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wbd      = {$urandom, $urandom};
            pc       = {$urandom, $urandom};
            cycle(1'b0, 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
